// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multi-port register file.
// Default geometry, flag bit positions, PC alias index and a clog2 helper.
package regfile_pkg;

  localparam int DEF_W      = 16;
  localparam int DEF_NREG   = 8;
  localparam int DEF_FW     = 16;
  localparam int DEF_PC_IDX = 3;

  localparam int FL_C = 0;
  localparam int FL_Z = 1;
  localparam int FL_V = 2;
  localparam int FL_N = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one registered read port with PC alias and hold-on-disable.
// Ports: clk, rst_n, en, addr, pc, arr_data in; data out (plus write buses
// for same-edge forwarding when REGFILE_BYPASS_EN is defined).
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int AW     = 3,
  parameter int NWP    = 2,
  parameter int PC_IDX = DEF_PC_IDX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [AW-1:0]   addr,
  input  logic [W-1:0]    pc,
  input  logic [W-1:0]    arr_data,
`ifdef REGFILE_BYPASS_EN
  input  logic [NWP-1:0]    wr_en,
  input  logic [NWP*AW-1:0] wr_addr,
  input  logic [NWP*W-1:0]  wr_data,
`endif
  output logic [W-1:0]    data
);

  logic [W-1:0] src;

`ifdef REGFILE_BYPASS_EN
  // Later ports overwrite earlier hits so the highest-index writer wins,
  // matching the array's collision rule.
  always_comb begin
    src = arr_data;
    for (int j = 0; j < NWP; j++) begin
      if (wr_en[j] && wr_addr[j*AW +: AW] == addr)
        src = wr_data[j*W +: W];
    end
    if (addr == AW'(PC_IDX))
      src = pc;
  end
`else
  always_comb begin
    src = arr_data;
    if (addr == AW'(PC_IDX))
      src = pc;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      data <= '0;
    else if (en)
      data <= src;
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with status flags.
// Ports: clk, rst_n (sync, active-low), rd_en/rd_addr/pc -> rd_data,
// wr_en/wr_addr/wr_data, fl_alu_we/fl_alu, fl_rmw_we/fl_rmw -> flags.
// Define REGFILE_BYPASS_EN for same-edge write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int NREG   = DEF_NREG,
  parameter int NRP    = 2,
  parameter int NWP    = 2,
  parameter int PC_IDX = DEF_PC_IDX,
  parameter int FW     = DEF_FW,
  localparam int AW    = clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRP-1:0]    rd_en,
  input  logic [NRP*AW-1:0] rd_addr,
  input  logic [W-1:0]      pc,
  output logic [NRP*W-1:0]  rd_data,
  input  logic [NWP-1:0]    wr_en,
  input  logic [NWP*AW-1:0] wr_addr,
  input  logic [NWP*W-1:0]  wr_data,
  input  logic              fl_alu_we,
  input  logic [FW-1:0]     fl_alu,
  input  logic              fl_rmw_we,
  input  logic [FW-1:0]     fl_rmw,
  output logic [FW-1:0]     flags
);

  logic [W-1:0] regs [NREG];

  // Ports applied in ascending order: the last NBA to an address wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++)
        regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWP; j++) begin
        if (wr_en[j])
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      flags <= '0;
    else if (fl_rmw_we)
      flags <= fl_rmw;
    else if (fl_alu_we)
      flags <= fl_alu;
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rp
    logic [W-1:0] arr_data;
    assign arr_data = regs[rd_addr[i*AW +: AW]];

    regfile_rdport #(
      .W      (W),
      .AW     (AW),
      .NWP    (NWP),
      .PC_IDX (PC_IDX)
    ) u_rp (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (rd_en[i]),
      .addr     (rd_addr[i*AW +: AW]),
      .pc       (pc),
      .arr_data (arr_data),
`ifdef REGFILE_BYPASS_EN
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
`endif
      .data     (rd_data[i*W +: W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp.
// Default 16-bit instance plus a W=32/NREG=16/NRP=3/NWP=1 instance.
module tb_regfile_mp;

  logic clk = 0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic        rst_n;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic [15:0] pc;
  logic [31:0] rd_data;
  logic [1:0]  wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        fl_alu_we, fl_rmw_we;
  logic [15:0] fl_alu, fl_rmw, flags;

  regfile_mp u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .pc(pc), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fl_alu_we(fl_alu_we), .fl_alu(fl_alu),
    .fl_rmw_we(fl_rmw_we), .fl_rmw(fl_rmw), .flags(flags)
  );

  logic        b_rst_n;
  logic [2:0]  b_rd_en;
  logic [11:0] b_rd_addr;
  logic [31:0] b_pc;
  logic [95:0] b_rd_data;
  logic [0:0]  b_wr_en;
  logic [3:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic [15:0] b_flags;

  regfile_mp #(.W(32), .NREG(16), .NRP(3), .NWP(1)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .pc(b_pc), .rd_data(b_rd_data),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .fl_alu_we(1'b0), .fl_alu(16'h0),
    .fl_rmw_we(1'b0), .fl_rmw(16'h0), .flags(b_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1; rd_en = 0; rd_addr = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    fl_alu_we = 0; fl_rmw_we = 0; fl_alu = 0; fl_rmw = 0;
  endtask

  task automatic wr0(input logic [2:0] a, input logic [15:0] d);
    wr_en = 2'b01; wr_addr = {3'd0, a}; wr_data = {16'h0, d};
  endtask

  logic [15:0] fwd_exp;
  logic [15:0] col_exp;
  logic [31:0] exp_b;
  int          a_b;

  initial begin
    idle();
    pc = 16'h0000;
    b_rst_n = 0; b_rd_en = 0; b_rd_addr = 0; b_pc = 32'hCAFE0000;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0;

    rst_n = 0; tick();
    check("rst_rd", rd_data, 0);
    check("rst_fl", flags, 0);
    rst_n = 1;

    wr0(3'd2, 16'h1234); fl_alu_we = 1; fl_alu = 16'hFFFF; tick();
    idle(); rd_en = 2'b01; rd_addr = 6'd2; tick();
    check("pre_rst_rd", rd_data, 32'h0000_1234);
    check("pre_rst_fl", flags, 16'hFFFF);
    idle(); rst_n = 0; tick();
    check("mid_rst_rd", rd_data, 0);
    check("mid_rst_fl", flags, 0);
    idle(); rd_en = 2'b01; rd_addr = 6'd2; tick();
    check("post_rst_r2", rd_data, 0);

    idle(); pc = 16'h0400; wr0(3'd3, 16'hAAAA); tick();
    idle(); rd_en = 2'b01; rd_addr = 6'd3; tick();
    check("pc_alias", rd_data[15:0], 16'h0400);
    idle(); pc = 16'h0402; rd_addr = 6'd3; tick();
    check("pc_hold", rd_data[15:0], 16'h0400);

    idle(); wr_en = 2'b11; wr_addr = {3'd5, 3'd5};
    wr_data = {16'h2222, 16'h1111}; tick();
    idle(); rd_en = 2'b11; rd_addr = {3'd5, 3'd5}; tick();
    check("collision", rd_data, 32'h2222_2222);
    idle(); rd_addr = {3'd5, 3'd5}; wr0(3'd5, 16'h5555); tick();
    check("hold_on_wr", rd_data, 32'h2222_2222);
    idle(); rd_en = 2'b10; rd_addr = {3'd5, 3'd0}; tick();
    check("port1_only", rd_data, 32'h5555_2222);

    idle(); wr0(3'd1, 16'h0001); tick();
`ifdef REGFILE_BYPASS_EN
    fwd_exp = 16'hBEEF;
    col_exp = 16'h7777;
`else
    fwd_exp = 16'h0001;
    col_exp = 16'h0000;
`endif
    idle(); wr0(3'd1, 16'hBEEF); rd_en = 2'b11;
    rd_addr = {3'd1, 3'd1}; tick();
    check("fwd_same", rd_data, {fwd_exp, fwd_exp});
    idle(); rd_en = 2'b11; rd_addr = {3'd1, 3'd1}; tick();
    check("fwd_next", rd_data, 32'hBEEF_BEEF);
    idle(); wr_en = 2'b11; wr_addr = {3'd6, 3'd6};
    wr_data = {16'h7777, 16'h6666}; rd_en = 2'b01; rd_addr = 6'd6; tick();
    check("fwd_col", rd_data[15:0], col_exp);
    idle(); wr0(3'd3, 16'h9999); rd_en = 2'b01; rd_addr = 6'd3; tick();
    check("pc_wr_alias", rd_data[15:0], 16'h0402);

    idle(); fl_alu_we = 1; fl_alu = 16'h0003;
    fl_rmw_we = 1; fl_rmw = 16'h0080; tick();
    check("fl_both", flags, 16'h0080);
    idle(); tick();
    check("fl_hold", flags, 16'h0080);
    idle(); fl_alu_we = 1; fl_alu = 16'h0003; tick();
    check("fl_alu", flags, 16'h0003);
    idle(); fl_rmw_we = 1; fl_rmw = 16'h0040; tick();
    check("fl_rmw", flags, 16'h0040);

    tick();
    check("b_rst", b_rd_data, 96'h0);
    b_rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      b_wr_en = 1'b1; b_wr_addr = 4'(i);
      b_wr_data = 32'(i) * 32'h01010101; tick();
    end
    b_wr_en = 0;
    for (int k = 0; k < 16; k++) begin
      b_rd_en = 3'b111;
      for (int p = 0; p < 3; p++)
        b_rd_addr[p*4 +: 4] = 4'((k + p) % 16);
      tick();
      for (int p = 0; p < 3; p++) begin
        a_b = (k + p) % 16;
        exp_b = (a_b == 3) ? b_pc : 32'(a_b) * 32'h01010101;
        check($sformatf("sweep_k%0d_p%0d", k, p),
              b_rd_data[p*32 +: 32], exp_b);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
